systolic_output_accumulator: RTL and testbench
==============================================

// Module: systolic_output_accumulator
// PURPOSE
//  Downstream of systolic_controller. Deskews per-column partial sums leaving the PE array.
//  Pairs them with the controller's write/output_addr/first_partial tag.
//  Read-modify-write accumulates them into the global output buffer: the first input tile
//  overwrites, later tiles add.
// PARAMETERS
//  PE_COL                16   array columns (lanes per buffer word)
//  ACC_W                 32   accumulator width per lane
//  global_buf_addr_width 17   buffer address width
//  ARRAY_LAT             16   cycles from write_in to column-0 psum_valid_in
// PORTS
//  clk             in   1              clock
//  rstn            in   1              async active-low reset
//  write_in        in   1              controller write strobe (one output row per cycle)
//  output_addr_in  in   AW             controller output_addr, same cycle as write_in
//  first_partial_in in  1              1 = first input tile: overwrite instead of accumulate
//  psum_in         in   PE_COL*ACC_W   column c at bits [c*ACC_W +: ACC_W]
//  psum_valid_in   in   PE_COL         column c valid, skewed: column c lags column 0 by c cycles
//  buf_rd_en       out  1              buffer read request
//  buf_rd_addr     out  AW             read address
//  buf_rd_data     in   PE_COL*ACC_W   read data, exactly 1 cycle after buf_rd_en
//  buf_wr_en       out  1              buffer write strobe
//  buf_wr_addr     out  AW             write address
//  buf_wr_data     out  PE_COL*ACC_W   accumulated row
//  busy            out  1              any tag or data in flight
//  err_align       out  1              sticky: aligned lane valids disagree with tag
// BEHAVIOUR
//  - Reset (async, rstn=0): all outputs 0; delay lines, pipeline regs, err_align and
//    forward register cleared. Reset mid-operation drops in-flight rows with no write.
//  - Tag line: {write_in, output_addr_in, first_partial_in} shifts through
//    ARRAY_LAT+PE_COL-1 registers.
//  - Deskew: column c data and valid are delayed PE_COL-1-c cycles, so all lanes align with
//    the tag tap. This is stage S0.
//  - S0 check: if the tag write bit is 1 and any lane valid is 0, or vice versa, set err_align.
//    The row is still processed using the tag write bit.
//  - S0, tag write=1, first=0: buf_rd_en=1, buf_rd_addr=tag addr (combinational from S0 regs).
//  - S0, tag write=1, first=1: no read issued.
//  - S1 (next cycle), per lane:
//      sum = psum + base
//      base = 0 when first=1
//      base = forward data when S1 addr == address written last cycle (buf_wr_en was 1)
//      base = buf_rd_data otherwise
//  - S1 registers buf_wr_en=1, buf_wr_addr, buf_wr_data=sum.
//  - Latency: aligned S0 -> buf_wr_en is 2 cycles. Total write_in -> buf_wr_en is
//    ARRAY_LAT+PE_COL+1. Throughput is 1 row/cycle with no stalls; the buffer must accept a
//    read and a write in the same cycle.
//  - Forwarding covers back-to-back rows to the same address. Rows 2 or more apart see
//    committed data.
//  - Arithmetic: lane add is ACC_W bits and wraps modulo 2^ACC_W. See ACC_SAT_EN.
//  - busy = OR of tag-line write bits, S0 valid and S1 valid. It deasserts the cycle after
//    the last buf_wr_en.
//  - Simultaneous write_in and an S1 write are independent; no backpressure exists.
//  - err_align clears only on reset.
// CONFIGURATION
//  ACC_SAT_EN defined: signed saturating lane add. Clamp to 2^(ACC_W-1)-1 or -2^(ACC_W-1)
//  on overflow; first=1 passes psum unchanged.
//  Not defined: two's-complement wrap.
// TESTING (PE_COL=4, ACC_W=32, ARRAY_LAT=2 unless noted)
//  1. Overwrite: write_in=1, addr=0x10, first=1, lanes {1,2,3,4} with correct skew
//     -> no buf_rd_en; buf_wr_en at +7 cycles, addr 0x10, data {1,2,3,4}.
//  2. Accumulate: buffer[0x20]={10,20,30,40}, first=0, lanes {1,1,1,1}
//     -> buf_rd_en addr 0x20; written {11,21,31,41}.
//  3. Forwarding: consecutive rows to 0x30, first=0, each lanes {5,5,5,5}, buffer holds 0
//     -> writes {5,...} then {10,...}, not {5,...} twice.
//  4. Skew error: drop column-2 valid on one row -> err_align=1 and stays 1; the row is
//     still written.
//  5. Overflow: buffer 0x7FFFFFFF, psum 1, first=0 -> 0x80000000 without macro;
//     0x7FFFFFFF with ACC_SAT_EN.
//  6. Reset mid-stream: assert rstn=0 with 3 rows in flight -> no buf_wr_en after release;
//     busy=0, err_align=0.

Source files
------------

// File: rtl/systolic_output_accumulator_if.sv
// rtl/systolic_output_accumulator_if.sv - controller/PE-array inputs and output-buffer port bundle
// slave = accumulator view, master = driver/buffer-model view.
interface systolic_output_accumulator_if #(
  parameter int PE_COL                = 16,
  parameter int ACC_W                 = 32,
  parameter int global_buf_addr_width = 17
);
  logic                             write_in;
  logic [global_buf_addr_width-1:0] output_addr_in;
  logic                             first_partial_in;
  logic [PE_COL*ACC_W-1:0]          psum_in;
  logic [PE_COL-1:0]                psum_valid_in;
  logic                             buf_rd_en;
  logic [global_buf_addr_width-1:0] buf_rd_addr;
  logic [PE_COL*ACC_W-1:0]          buf_rd_data;
  logic                             buf_wr_en;
  logic [global_buf_addr_width-1:0] buf_wr_addr;
  logic [PE_COL*ACC_W-1:0]          buf_wr_data;
  logic                             busy;
  logic                             err_align;

  modport slave (
    input  write_in, output_addr_in, first_partial_in, psum_in, psum_valid_in, buf_rd_data,
    output buf_rd_en, buf_rd_addr, buf_wr_en, buf_wr_addr, buf_wr_data, busy, err_align
  );

  modport master (
    output write_in, output_addr_in, first_partial_in, psum_in, psum_valid_in, buf_rd_data,
    input  buf_rd_en, buf_rd_addr, buf_wr_en, buf_wr_addr, buf_wr_data, busy, err_align
  );
endinterface

// File: rtl/systolic_output_accumulator.sv
// rtl/systolic_output_accumulator.sv - deskew PE column psums and read-modify-write them into the output buffer
// Optional ACC_SAT_EN: signed saturating lane add instead of two's-complement wrap.
module systolic_output_accumulator #(
  parameter int PE_COL                = 16,
  parameter int ACC_W                 = 32,
  parameter int global_buf_addr_width = 17,
  parameter int ARRAY_LAT             = 16
) (
  input logic                          clk,
  input logic                          rstn,
  systolic_output_accumulator_if.slave bus
);
  localparam int AW      = global_buf_addr_width;
  localparam int DW      = PE_COL * ACC_W;
  localparam int TAG_LEN = ARRAY_LAT + PE_COL - 1;

  // Tag line: the controller tag travels alongside the array so it meets the deskewed row.
  logic [TAG_LEN-1:0] tag_wr_q;
  logic [TAG_LEN-1:0] tag_first_q;
  logic [AW-1:0]      tag_addr_q [TAG_LEN];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_wr_q    <= '0;
      tag_first_q <= '0;
      for (int i = 0; i < TAG_LEN; i++) tag_addr_q[i] <= '0;
    end else begin
      tag_wr_q[0]    <= bus.write_in;
      tag_first_q[0] <= bus.first_partial_in;
      tag_addr_q[0]  <= bus.output_addr_in;
      for (int i = 1; i < TAG_LEN; i++) begin
        tag_wr_q[i]    <= tag_wr_q[i-1];
        tag_first_q[i] <= tag_first_q[i-1];
        tag_addr_q[i]  <= tag_addr_q[i-1];
      end
    end
  end

  logic          s0_wr;
  logic          s0_first;
  logic [AW-1:0] s0_addr;

  assign s0_wr    = tag_wr_q[TAG_LEN-1];
  assign s0_first = tag_first_q[TAG_LEN-1];
  assign s0_addr  = tag_addr_q[TAG_LEN-1];

  logic [DW-1:0]     s0_psum;
  logic [PE_COL-1:0] s0_lane_vld;

  for (genvar c = 0; c < PE_COL; c++) begin : g_deskew
    localparam int D = PE_COL - 1 - c;
    if (D == 0) begin : g_pass
      assign s0_psum[c*ACC_W +: ACC_W] = bus.psum_in[c*ACC_W +: ACC_W];
      assign s0_lane_vld[c]            = bus.psum_valid_in[c];
    end else begin : g_dly
      logic [ACC_W-1:0] dat_q [D];
      logic [D-1:0]     vld_q;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          vld_q <= '0;
          for (int i = 0; i < D; i++) dat_q[i] <= '0;
        end else begin
          vld_q[0] <= bus.psum_valid_in[c];
          dat_q[0] <= bus.psum_in[c*ACC_W +: ACC_W];
          for (int i = 1; i < D; i++) begin
            vld_q[i] <= vld_q[i-1];
            dat_q[i] <= dat_q[i-1];
          end
        end
      end

      assign s0_psum[c*ACC_W +: ACC_W] = dat_q[D-1];
      assign s0_lane_vld[c]            = vld_q[D-1];
    end
  end

  // Alignment is only monitored; the tag write bit alone decides whether a row is processed.
  logic lane_mismatch;
  logic err_align_q;

  assign lane_mismatch = s0_wr ? ~(&s0_lane_vld) : (|s0_lane_vld);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_align_q <= 1'b0;
    else       err_align_q <= err_align_q | lane_mismatch;
  end

  assign bus.buf_rd_en   = s0_wr & ~s0_first;
  assign bus.buf_rd_addr = s0_addr;

  logic          s1_vld_q;
  logic          s1_first_q;
  logic [AW-1:0] s1_addr_q;
  logic [DW-1:0] s1_psum_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_psum_q  <= '0;
    end else begin
      s1_vld_q <= s0_wr;
      if (s0_wr) begin
        s1_first_q <= s0_first;
        s1_addr_q  <= s0_addr;
        s1_psum_q  <= s0_psum;
      end
    end
  end

  function automatic logic [ACC_W-1:0] lane_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
    logic [ACC_W-1:0] s;
    s = a + b;
`ifdef ACC_SAT_EN
    if ((a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]))
      s = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`endif
    return s;
  endfunction

  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [DW-1:0] wr_data_q;
  logic [DW-1:0] wr_data_d;
  logic          fwd_hit;

  // The row being written this cycle is not yet visible in buf_rd_data, so forward it.
  always_comb begin
    wr_data_d = '0;
    fwd_hit   = wr_en_q && (wr_addr_q == s1_addr_q);
    for (int c = 0; c < PE_COL; c++) begin
      logic [ACC_W-1:0] base;
      if (s1_first_q)   base = '0;
      else if (fwd_hit) base = wr_data_q[c*ACC_W +: ACC_W];
      else              base = bus.buf_rd_data[c*ACC_W +: ACC_W];
      wr_data_d[c*ACC_W +: ACC_W] = lane_add(s1_psum_q[c*ACC_W +: ACC_W], base);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= s1_vld_q;
      if (s1_vld_q) begin
        wr_addr_q <= s1_addr_q;
        wr_data_q <= wr_data_d;
      end
    end
  end

  assign bus.buf_wr_en   = wr_en_q;
  assign bus.buf_wr_addr = wr_addr_q;
  assign bus.buf_wr_data = wr_data_q;
  assign bus.busy        = (|tag_wr_q) | s1_vld_q | wr_en_q;
  assign bus.err_align   = err_align_q;
endmodule

// File: tb/tb_systolic_output_accumulator.sv
// tb/tb_systolic_output_accumulator.sv - directed checks of deskew, accumulate, forwarding, errors and reset
module tb_systolic_output_accumulator;
  localparam int PE_COL = 4;
  localparam int ACC_W  = 32;
  localparam int AW     = 17;
  localparam int ALAT   = 2;
  localparam int DW     = PE_COL * ACC_W;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  systolic_output_accumulator_if #(.PE_COL(PE_COL), .ACC_W(ACC_W), .global_buf_addr_width(AW)) bus ();

  systolic_output_accumulator #(
    .PE_COL(PE_COL), .ACC_W(ACC_W), .global_buf_addr_width(AW), .ARRAY_LAT(ALAT)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  // Output buffer model: write-first, read data one cycle after the request.
  logic [DW-1:0] mem [256];
  logic          pl_en = 1'b0;
  logic [7:0]    pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  int            cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pl_en) mem[pl_addr] = pl_data;
    if (bus.buf_wr_en) mem[bus.buf_wr_addr[7:0]] = bus.buf_wr_data;
    if (bus.buf_rd_en) bus.buf_rd_data <= mem[bus.buf_rd_addr[7:0]];
  end

  logic [AW-1:0] wq_addr [$];
  logic [DW-1:0] wq_data [$];
  int            wq_cyc  [$];
  logic          wq_busy [$];
  logic [AW-1:0] rq_addr [$];

  always @(negedge clk) begin
    if (bus.buf_wr_en) begin
      wq_addr.push_back(bus.buf_wr_addr);
      wq_data.push_back(bus.buf_wr_data);
      wq_cyc.push_back(cyc);
      wq_busy.push_back(bus.busy);
    end
    if (bus.buf_rd_en) rq_addr.push_back(bus.buf_rd_addr);
  end

  logic [PE_COL-1:0] sv [64];
  logic [DW-1:0]     sd [64];
  int n_chk  = 0;
  int n_pass = 0;
  int last_issue = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] pack(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  task automatic clear_slots();
    for (int i = 0; i < 64; i++) begin
      sv[i] = '0;
      sd[i] = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.write_in         = 1'b0;
    bus.first_partial_in = 1'b0;
    bus.output_addr_in   = '0;
    bus.psum_valid_in    = sv[cyc % 64];
    bus.psum_in          = sd[cyc % 64];
    sv[cyc % 64]         = '0;
    sd[cyc % 64]         = '0;
  endtask

  // Column c of the row reaches the accumulator ALAT+c cycles after the tag.
  task automatic row(input logic [AW-1:0] addr, input logic first, input logic [DW-1:0] lanes,
                     input logic [PE_COL-1:0] mask);
    bus.write_in         = 1'b1;
    bus.output_addr_in   = addr;
    bus.first_partial_in = first;
    last_issue           = cyc;
    for (int c = 0; c < PE_COL; c++) begin
      sv[(cyc + ALAT + c) % 64][c]           = mask[c];
      sd[(cyc + ALAT + c) % 64][c*32 +: 32]  = lanes[c*32 +: 32];
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [DW-1:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_en   = 1'b0;
  endtask

  task automatic wait_writes(input int n);
    int budget;
    budget = 40;
    while (wq_addr.size() < n && budget > 0) begin
      tick();
      budget--;
    end
    chk("wr_arrive", 128'(wq_addr.size() >= n), 128'd1);
  endtask

  int base;
  int rb;
  logic [DW-1:0] exp5;

  initial begin
    rstn                 = 1'b0;
    bus.write_in         = 1'b0;
    bus.output_addr_in   = '0;
    bus.first_partial_in = 1'b0;
    bus.psum_in          = '0;
    bus.psum_valid_in    = '0;
    clear_slots();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", 128'(bus.buf_wr_en), 128'd0);
    chk("rst_rd_en", 128'(bus.buf_rd_en), 128'd0);
    chk("rst_busy", 128'(bus.busy), 128'd0);
    chk("rst_err", 128'(bus.err_align), 128'd0);
    chk("rst_wr_data", bus.buf_wr_data, 128'd0);
    rstn = 1'b1;
    tick();

    // Overwrite: stale buffer contents must be ignored and no read issued.
    preload(8'h10, pack(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF));
    base = wq_addr.size();
    rb   = rq_addr.size();
    row(17'h10, 1'b1, pack(1, 2, 3, 4), 4'hF);
    tick();
    chk("t1_busy_inflight", 128'(bus.busy), 128'd1);
    wait_writes(base + 1);
    chk("t1_no_rd", 128'(rq_addr.size() - rb), 128'd0);
    chk("t1_addr", 128'(wq_addr[base]), 128'h10);
    chk("t1_data", wq_data[base], pack(1, 2, 3, 4));
    chk("t1_latency", 128'(wq_cyc[base] - last_issue), 128'd7);
    chk("t1_busy_at_wr", 128'(wq_busy[base]), 128'd1);
    chk("t1_busy_after", 128'(bus.busy), 128'd0);

    // Accumulate onto committed buffer data.
    preload(8'h20, pack(10, 20, 30, 40));
    base = wq_addr.size();
    rb   = rq_addr.size();
    row(17'h20, 1'b0, pack(1, 1, 1, 1), 4'hF);
    tick();
    wait_writes(base + 1);
    chk("t2_rd_count", 128'(rq_addr.size() - rb), 128'd1);
    chk("t2_rd_addr", 128'(rq_addr[rb]), 128'h20);
    chk("t2_data", wq_data[base], pack(11, 21, 31, 41));

    // Back-to-back rows to one address need forwarding.
    preload(8'h30, '0);
    base = wq_addr.size();
    row(17'h30, 1'b0, pack(5, 5, 5, 5), 4'hF);
    tick();
    row(17'h30, 1'b0, pack(5, 5, 5, 5), 4'hF);
    tick();
    wait_writes(base + 2);
    chk("t3_first", wq_data[base], pack(5, 5, 5, 5));
    chk("t3_fwd", wq_data[base+1], pack(10, 10, 10, 10));

    // Rows two cycles apart read the committed value.
    preload(8'h40, pack(100, 100, 100, 100));
    base = wq_addr.size();
    row(17'h40, 1'b0, pack(1, 2, 3, 4), 4'hF);
    tick();
    tick();
    row(17'h40, 1'b0, pack(1, 2, 3, 4), 4'hF);
    tick();
    wait_writes(base + 2);
    chk("t3b_first", wq_data[base], pack(101, 102, 103, 104));
    chk("t3b_gap2", wq_data[base+1], pack(102, 104, 106, 108));
    chk("err_clean", 128'(bus.err_align), 128'd0);

    // Dropped column-2 valid: sticky error, row still written.
    base = wq_addr.size();
    row(17'h50, 1'b1, pack(7, 8, 9, 10), 4'b1011);
    tick();
    wait_writes(base + 1);
    chk("t4_data", wq_data[base], pack(7, 8, 9, 10));
    chk("t4_err_set", 128'(bus.err_align), 128'd1);
    base = wq_addr.size();
    row(17'h51, 1'b1, pack(1, 1, 1, 1), 4'hF);
    tick();
    wait_writes(base + 1);
    chk("t4_err_sticky", 128'(bus.err_align), 128'd1);

    // Signed overflow at both ends, plus a carry-out that is not a signed overflow.
    preload(8'h60, pack(32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'h80000000));
    base = wq_addr.size();
    row(17'h60, 1'b0, pack(32'd1, 32'd1, 32'd1, 32'hFFFFFFFF), 4'hF);
    tick();
    wait_writes(base + 1);
`ifdef ACC_SAT_EN
    exp5 = pack(32'h7FFFFFFF, 32'd6, 32'h0, 32'h80000000);
`else
    exp5 = pack(32'h80000000, 32'd6, 32'h0, 32'h7FFFFFFF);
`endif
    chk("t5_overflow", wq_data[base], exp5);

    // Reset with three rows in flight: nothing may be written afterwards.
    base = wq_addr.size();
    row(17'h70, 1'b1, pack(1, 1, 1, 1), 4'hF);
    tick();
    row(17'h71, 1'b1, pack(2, 2, 2, 2), 4'hF);
    tick();
    row(17'h72, 1'b1, pack(3, 3, 3, 3), 4'hF);
    tick();
    #2;
    rstn = 1'b0;
    bus.psum_valid_in = '0;
    bus.psum_in       = '0;
    clear_slots();
    #1;
    chk("t6_busy_in_rst", 128'(bus.busy), 128'd0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (15) tick();
    chk("t6_no_write", 128'(wq_addr.size() - base), 128'd0);
    chk("t6_busy", 128'(bus.busy), 128'd0);
    chk("t6_err", 128'(bus.err_align), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
